id_ex_pipe_reg: RTL and testbench

//  ID/EX pipeline register of the MIPS pipeline, directly downstream of the decode controller.

---
 rtl/id_ex_pipe_reg.sv | 182 ++++++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection and a saturating stall counter.
// Resolves the write-destination register and suppresses writes to $0.
module id_ex_pipe_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              flush_in,
  input  logic [1:0]        id_RegDst,
  input  logic [1:0]        id_Jmp,
  input  logic              id_DataC,
  input  logic              id_Regwrite,
  input  logic              id_AluSrc,
  input  logic              id_AluSrc1,
  input  logic              id_Branch,
  input  logic              id_not_equal_Branch,
  input  logic              id_MemRead,
  input  logic              id_MemWrite,
  input  logic              id_MemtoReg,
  input  logic [3:0]        id_AluOperation,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_shamt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  output logic [1:0]        ex_RegDst,
  output logic [1:0]        ex_Jmp,
  output logic              ex_DataC,
  output logic              ex_Regwrite,
  output logic              ex_AluSrc,
  output logic              ex_AluSrc1,
  output logic              ex_Branch,
  output logic              ex_not_equal_Branch,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic              ex_MemtoReg,
  output logic [3:0]        ex_AluOperation,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_shamt,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [REG_AW-1:0] ex_wr_reg,
  output logic              ex_valid,
  output logic              pc_write,
  output logic              ifid_write,
  output logic [CNT_W-1:0]  stall_count
);

  typedef struct packed {
    logic [1:0] RegDst;
    logic [1:0] Jmp;
    logic       DataC;
    logic       Regwrite;
    logic       AluSrc;
    logic       AluSrc1;
    logic       Branch;
    logic       not_equal_Branch;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic [3:0] AluOperation;
  } ctrl_t;

  ctrl_t              r_ctrl;
  ctrl_t              w_ctrl_in;
  logic [DATA_W-1:0]  r_pc4, r_rs_data, r_rt_data, r_imm;
  logic [4:0]         r_shamt;
  logic [REG_AW-1:0]  r_rs, r_rt, r_rd, r_wr_reg;
  logic               r_valid;
  logic [CNT_W-1:0]   r_stall_count;

  logic [REG_AW-1:0]  w_dest;
  logic               w_uses_rs, w_uses_rt, w_hazard, w_stall;

  always_comb begin
    w_dest = '0;
    case (id_RegDst)
      2'b00:   w_dest = id_rt;
      2'b01:   w_dest = id_rd;
      2'b10:   w_dest = REG_AW'(31);
      default: w_dest = '0;
    endcase
  end

  assign w_uses_rs = ~id_AluSrc1 & (id_Jmp != 2'b01);
  assign w_uses_rt = ~id_AluSrc | id_MemWrite | id_Branch | id_not_equal_Branch;
  assign w_hazard  = r_valid & r_ctrl.MemRead & (r_rt != '0) & id_valid &
                     ((w_uses_rs & (r_rt == id_rs)) | (w_uses_rt & (r_rt == id_rt)));
  assign w_stall   = w_hazard & ~flush_in;

  // Invalid slots carry no control so they behave exactly like a bubble downstream.
  always_comb begin
    w_ctrl_in = '0;
    if (id_valid) begin
      w_ctrl_in.RegDst           = id_RegDst;
      w_ctrl_in.Jmp              = id_Jmp;
      w_ctrl_in.DataC            = id_DataC;
      w_ctrl_in.Regwrite         = id_Regwrite & (w_dest != '0);
      w_ctrl_in.AluSrc           = id_AluSrc;
      w_ctrl_in.AluSrc1          = id_AluSrc1;
      w_ctrl_in.Branch           = id_Branch;
      w_ctrl_in.not_equal_Branch = id_not_equal_Branch;
      w_ctrl_in.MemRead          = id_MemRead;
      w_ctrl_in.MemWrite         = id_MemWrite;
      w_ctrl_in.MemtoReg         = id_MemtoReg;
      w_ctrl_in.AluOperation     = id_AluOperation;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || flush_in || w_stall) begin
      r_ctrl    <= '0;
      r_pc4     <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_shamt   <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_wr_reg  <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_ctrl    <= w_ctrl_in;
      r_pc4     <= id_pc4;
      r_rs_data <= id_rs_data;
      r_rt_data <= id_rt_data;
      r_imm     <= id_imm;
      r_shamt   <= id_shamt;
      r_rs      <= id_rs;
      r_rt      <= id_rt;
      r_rd      <= id_rd;
      r_wr_reg  <= w_dest;
      r_valid   <= id_valid;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign ex_RegDst           = r_ctrl.RegDst;
  assign ex_Jmp              = r_ctrl.Jmp;
  assign ex_DataC            = r_ctrl.DataC;
  assign ex_Regwrite         = r_ctrl.Regwrite;
  assign ex_AluSrc           = r_ctrl.AluSrc;
  assign ex_AluSrc1          = r_ctrl.AluSrc1;
  assign ex_Branch           = r_ctrl.Branch;
  assign ex_not_equal_Branch = r_ctrl.not_equal_Branch;
  assign ex_MemRead          = r_ctrl.MemRead;
  assign ex_MemWrite         = r_ctrl.MemWrite;
  assign ex_MemtoReg         = r_ctrl.MemtoReg;
  assign ex_AluOperation     = r_ctrl.AluOperation;
  assign ex_pc4              = r_pc4;
  assign ex_rs_data          = r_rs_data;
  assign ex_rt_data          = r_rt_data;
  assign ex_imm              = r_imm;
  assign ex_shamt            = r_shamt;
  assign ex_rs               = r_rs;
  assign ex_rt               = r_rt;
  assign ex_rd               = r_rd;
  assign ex_wr_reg           = r_wr_reg;
  assign ex_valid            = r_valid;
  assign pc_write            = ~w_stall;
  assign ifid_write          = ~w_stall;
  assign stall_count         = r_stall_count;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: a per-cycle reference model of the EX slot plus literal spot checks.
// A second instance with a 4-bit counter shares the stimulus so saturation is reachable quickly.
module tb_id_ex_pipe_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, flush_in;
  logic [1:0]  id_RegDst, id_Jmp;
  logic        id_DataC, id_Regwrite, id_AluSrc, id_AluSrc1, id_Branch, id_not_equal_Branch;
  logic        id_MemRead, id_MemWrite, id_MemtoReg;
  logic [3:0]  id_AluOperation;
  logic [31:0] id_pc4, id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_shamt, id_rs, id_rt, id_rd;

  logic [1:0]  ex_RegDst, ex_Jmp;
  logic        ex_DataC, ex_Regwrite, ex_AluSrc, ex_AluSrc1, ex_Branch, ex_not_equal_Branch;
  logic        ex_MemRead, ex_MemWrite, ex_MemtoReg;
  logic [3:0]  ex_AluOperation;
  logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_shamt, ex_rs, ex_rt, ex_rd, ex_wr_reg;
  logic        ex_valid, pc_write, ifid_write;
  logic [15:0] stall_count;

  logic [1:0]  s_RegDst, s_Jmp;
  logic        s_DataC, s_Regwrite, s_AluSrc, s_AluSrc1, s_Branch, s_not_equal_Branch;
  logic        s_MemRead, s_MemWrite, s_MemtoReg;
  logic [3:0]  s_AluOperation;
  logic [31:0] s_pc4, s_rs_data, s_rt_data, s_imm;
  logic [4:0]  s_shamt, s_rs, s_rt, s_rd, s_wr_reg;
  logic        s_valid, s_pc_write, s_ifid_write;
  logic [3:0]  s_stall_count;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .flush_in(flush_in),
    .id_RegDst(id_RegDst), .id_Jmp(id_Jmp), .id_DataC(id_DataC), .id_Regwrite(id_Regwrite),
    .id_AluSrc(id_AluSrc), .id_AluSrc1(id_AluSrc1), .id_Branch(id_Branch),
    .id_not_equal_Branch(id_not_equal_Branch), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
    .id_MemtoReg(id_MemtoReg), .id_AluOperation(id_AluOperation), .id_pc4(id_pc4),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_shamt(id_shamt),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_RegDst(ex_RegDst), .ex_Jmp(ex_Jmp), .ex_DataC(ex_DataC), .ex_Regwrite(ex_Regwrite),
    .ex_AluSrc(ex_AluSrc), .ex_AluSrc1(ex_AluSrc1), .ex_Branch(ex_Branch),
    .ex_not_equal_Branch(ex_not_equal_Branch), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
    .ex_MemtoReg(ex_MemtoReg), .ex_AluOperation(ex_AluOperation), .ex_pc4(ex_pc4),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_shamt(ex_shamt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_wr_reg(ex_wr_reg), .ex_valid(ex_valid),
    .pc_write(pc_write), .ifid_write(ifid_write), .stall_count(stall_count)
  );

  id_ex_pipe_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .flush_in(flush_in),
    .id_RegDst(id_RegDst), .id_Jmp(id_Jmp), .id_DataC(id_DataC), .id_Regwrite(id_Regwrite),
    .id_AluSrc(id_AluSrc), .id_AluSrc1(id_AluSrc1), .id_Branch(id_Branch),
    .id_not_equal_Branch(id_not_equal_Branch), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
    .id_MemtoReg(id_MemtoReg), .id_AluOperation(id_AluOperation), .id_pc4(id_pc4),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_shamt(id_shamt),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_RegDst(s_RegDst), .ex_Jmp(s_Jmp), .ex_DataC(s_DataC), .ex_Regwrite(s_Regwrite),
    .ex_AluSrc(s_AluSrc), .ex_AluSrc1(s_AluSrc1), .ex_Branch(s_Branch),
    .ex_not_equal_Branch(s_not_equal_Branch), .ex_MemRead(s_MemRead), .ex_MemWrite(s_MemWrite),
    .ex_MemtoReg(s_MemtoReg), .ex_AluOperation(s_AluOperation), .ex_pc4(s_pc4),
    .ex_rs_data(s_rs_data), .ex_rt_data(s_rt_data), .ex_imm(s_imm), .ex_shamt(s_shamt),
    .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd), .ex_wr_reg(s_wr_reg), .ex_valid(s_valid),
    .pc_write(s_pc_write), .ifid_write(s_ifid_write), .stall_count(s_stall_count)
  );

  // Reference view of the EX slot; dk=0 marks data fields the model does not pin down.
  typedef struct packed {
    logic [1:0]  RegDst;
    logic [1:0]  Jmp;
    logic        DataC, Regwrite, AluSrc, AluSrc1, Branch, neb, MemRead, MemWrite, MemtoReg;
    logic [3:0]  op;
    logic [31:0] pc4, rs_data, rt_data, imm;
    logic [4:0]  shamt, rs, rt, rd, wr_reg;
    logic        valid;
    logic        dk;
  } ex_t;

  ex_t         m;
  int unsigned m_cnt;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_hazard();
    logic reads_rs, reads_rt, ld_in_ex;
    reads_rs = !id_AluSrc1 && id_Jmp != 2'b01;
    reads_rt = !id_AluSrc || id_MemWrite || id_Branch || id_not_equal_Branch;
    ld_in_ex = m.valid && m.MemRead && m.rt != 5'd0;
    return ld_in_ex && id_valid && ((reads_rs && m.rt == id_rs) || (reads_rt && m.rt == id_rt));
  endfunction

  always @(posedge clk or negedge rst) begin
    ex_t nx;
    nx = '0;
    nx.dk = 1'b1;
    if (rst && !flush_in && m_hazard()) begin
      m_cnt <= m_cnt + 1;
    end else if (!rst) begin
      m_cnt <= 0;
    end else if (!flush_in) begin
      case (id_RegDst)
        2'd0: nx.wr_reg = id_rt;
        2'd1: nx.wr_reg = id_rd;
        2'd2: nx.wr_reg = 5'd31;
        default: nx.wr_reg = 5'd0;
      endcase
      nx.pc4 = id_pc4; nx.rs_data = id_rs_data; nx.rt_data = id_rt_data; nx.imm = id_imm;
      nx.shamt = id_shamt; nx.rs = id_rs; nx.rt = id_rt; nx.rd = id_rd;
      nx.valid = id_valid;
      nx.dk = id_valid;
      if (id_valid) begin
        nx.RegDst = id_RegDst; nx.Jmp = id_Jmp; nx.DataC = id_DataC;
        nx.Regwrite = id_Regwrite && nx.wr_reg != 5'd0;
        nx.AluSrc = id_AluSrc; nx.AluSrc1 = id_AluSrc1; nx.Branch = id_Branch;
        nx.neb = id_not_equal_Branch; nx.MemRead = id_MemRead; nx.MemWrite = id_MemWrite;
        nx.MemtoReg = id_MemtoReg; nx.op = id_AluOperation;
      end
    end
    m <= nx;
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("ctrl", {ex_RegDst, ex_Jmp, ex_DataC, ex_Regwrite, ex_AluSrc, ex_AluSrc1, ex_Branch,
                   ex_not_equal_Branch, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_AluOperation},
                  {m.RegDst, m.Jmp, m.DataC, m.Regwrite, m.AluSrc, m.AluSrc1, m.Branch,
                   m.neb, m.MemRead, m.MemWrite, m.MemtoReg, m.op});
      chk("valid", ex_valid, m.valid);
      if (m.dk) begin
        chk("wr_reg", ex_wr_reg, m.wr_reg);
        chk("data", {ex_pc4, ex_rs_data, ex_rt_data, ex_imm}, {m.pc4, m.rs_data, m.rt_data, m.imm});
        chk("idx", {ex_shamt, ex_rs, ex_rt, ex_rd}, {m.shamt, m.rs, m.rt, m.rd});
      end
      chk("pc_write", pc_write, !(m_hazard() && !flush_in));
      chk("ifid_write", ifid_write, !(m_hazard() && !flush_in));
      chk("stall_count", stall_count, m_cnt[15:0]);
      chk("sat_count", s_stall_count, (m_cnt > 15) ? 4'hF : m_cnt[3:0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [1:0] regdst, input logic [1:0] jmp,
                       input logic regwr, input logic alusrc, input logic alusrc1,
                       input logic memrd, input logic memwr, input logic br, input logic neb,
                       input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd);
    id_valid = v; id_RegDst = regdst; id_Jmp = jmp; id_Regwrite = regwr;
    id_AluSrc = alusrc; id_AluSrc1 = alusrc1; id_MemRead = memrd; id_MemWrite = memwr;
    id_Branch = br; id_not_equal_Branch = neb; id_AluOperation = op;
    id_rs = rs; id_rt = rt; id_rd = rd;
    id_DataC = (jmp != 2'b00);
    id_MemtoReg = memrd;
    id_pc4 = 32'h0040_0000 + ($urandom_range(0, 4095) << 2);
    id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
    id_shamt = 5'($urandom_range(0, 31));
  endtask

  task automatic lw(input logic [4:0] rs, input logic [4:0] rt);
    drive(1, 2'b00, 2'b00, 1, 1, 0, 1, 0, 0, 0, 4'b0010, rs, rt, 5'd0);
  endtask

  task automatic add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    drive(1, 2'b01, 2'b00, 1, 0, 0, 0, 0, 0, 0, 4'b0000, rs, rt, rd);
  endtask

  initial begin
    rst = 1'b0; flush_in = 1'b0;
    drive(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'd0, 5'd0, 5'd0, 5'd0);
    #1;
    chk("rst_valid", ex_valid, 1'b0);
    chk("rst_wr_reg", ex_wr_reg, 5'd0);
    chk("rst_count", stall_count, 16'd0);
    chk("rst_pc_write", pc_write, 1'b1);
    tick();
    rst = 1'b1;

    add(5'd1, 5'd2, 5'd5);
    tick();
    chk("cap_wr_reg", ex_wr_reg, 5'd5);
    chk("cap_regwrite", ex_Regwrite, 1'b1);
    chk("cap_aluop", ex_AluOperation, 4'b0000);
    chk("cap_valid", ex_valid, 1'b1);

    lw(5'd4, 5'd8);
    tick();
    add(5'd8, 5'd9, 5'd10);
    #1;
    chk("lu_pc_write", pc_write, 1'b0);
    chk("lu_ifid_write", ifid_write, 1'b0);
    tick();
    chk("lu_bubble", ex_valid, 1'b0);
    chk("lu_bubble_rd", ex_MemRead, 1'b0);
    chk("lu_count", stall_count, 16'd1);
    chk("lu_release", pc_write, 1'b1);
    tick();
    chk("lu_issue_valid", ex_valid, 1'b1);
    chk("lu_issue_wr", ex_wr_reg, 5'd10);

    lw(5'd4, 5'd8);
    tick();
    drive(1, 2'b00, 2'b00, 1, 1, 0, 0, 0, 0, 0, 4'b0010, 5'd3, 5'd8, 5'd0);
    #1;
    chk("addi_no_stall", pc_write, 1'b1);
    tick();
    chk("addi_wr", ex_wr_reg, 5'd8);

    lw(5'd4, 5'd0);
    tick();
    chk("lw_r0_regwrite", ex_Regwrite, 1'b0);
    add(5'd0, 5'd0, 5'd3);
    #1;
    chk("r0_no_stall", pc_write, 1'b1);
    tick();

    lw(5'd4, 5'd8);
    tick();
    add(5'd8, 5'd9, 5'd10);
    flush_in = 1'b1;
    #1;
    chk("flush_pc_write", pc_write, 1'b1);
    tick();
    flush_in = 1'b0;
    chk("flush_bubble", ex_valid, 1'b0);
    chk("flush_count", stall_count, 16'd1);

    lw(5'd4, 5'd7); tick();
    drive(1, 2'b00, 2'b00, 0, 1, 0, 0, 1, 0, 0, 4'b0010, 5'd2, 5'd7, 5'd0); tick(); tick();
    lw(5'd4, 5'd6); tick();
    drive(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 4'b0110, 5'd1, 5'd6, 5'd0); tick(); tick();
    lw(5'd4, 5'd6); tick();
    drive(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 4'b0110, 5'd6, 5'd1, 5'd0); tick(); tick();
    lw(5'd4, 5'd8); tick();
    drive(1, 2'b10, 2'b01, 1, 1, 0, 0, 0, 0, 0, 4'b0000, 5'd8, 5'd8, 5'd0); tick();
    chk("jal_wr", ex_wr_reg, 5'd31);
    lw(5'd4, 5'd8); tick();
    drive(1, 2'b00, 2'b10, 0, 1, 0, 0, 0, 0, 0, 4'b0000, 5'd8, 5'd0, 5'd0); tick(); tick();
    drive(1, 2'b00, 2'b10, 1, 1, 0, 0, 0, 0, 0, 4'b0000, 5'd9, 5'd12, 5'd0); tick();
    chk("jalr_wr", ex_wr_reg, 5'd12);
    lw(5'd4, 5'd8); tick();
    drive(0, 2'b01, 2'b00, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 5'd8, 5'd8, 5'd9); tick();
    chk("inv_valid", ex_valid, 1'b0);
    chk("inv_regwrite", ex_Regwrite, 1'b0);
    drive(1, 2'b11, 2'b00, 1, 0, 0, 0, 0, 0, 0, 4'b0001, 5'd1, 5'd2, 5'd3); tick();
    chk("regdst11_wr", ex_wr_reg, 5'd0);
    chk("regdst11_rw", ex_Regwrite, 1'b0);

    for (int i = 0; i < 40; i++) begin
      lw(5'd8, 5'd8);
      tick();
    end
    chk("sat_reached", s_stall_count, 4'hF);
    lw(5'd8, 5'd8); tick();
    lw(5'd8, 5'd8); tick();
    chk("sat_hold", s_stall_count, 4'hF);

    lw(5'd4, 5'd8); tick();
    add(5'd8, 5'd9, 5'd10);
    #1;
    chk("pre_rst_stall", pc_write, 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", ex_valid, 1'b0);
    chk("mid_rst_memrd", ex_MemRead, 1'b0);
    chk("mid_rst_pc4", ex_pc4, 32'd0);
    chk("mid_rst_count", stall_count, 16'd0);
    chk("mid_rst_pc_write", pc_write, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_issue", ex_wr_reg, 5'd10);
    chk("post_rst_count", stall_count, 16'd0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
